// File: rtl/sayac_ctrl_pkg.sv
// Shared control definitions for SAYAC datapath sequencers: FSM state
// encoding and the shift-length clamp used when a transfer is accepted.
package sayac_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A zero or oversized length means "shift the whole register".
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned size);
    if (len == 0 || len > size)
      return size;
    return len;
  endfunction

endpackage

// File: rtl/shift_down_counter.sv
// Loadable down-counter tracking the shifts still owed; never wraps below zero.
module shift_down_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (ld)
      cnt <= ld_val;
    else if (dec && cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Sequences a shift_register through load, N right-shifts and a done pulse,
// with stall (hold) and cancel (abort) from the requesting unit.
module shift_sequencer
  import sayac_ctrl_pkg::*;
#(
  parameter int size  = 16,
  parameter int CNT_W = $clog2(size + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_len,
  input  logic             hold,
  input  logic             abort,
  output logic             ldR,
  output logic             shrR,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shifts_left
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_one;
  logic             cnt_ld, cnt_dec, cnt_clr;

  always_ff @(posedge clk) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Effective length is fixed at acceptance; later shift_len changes are ignored.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start)
      len_q <= CNT_W'(clamp_len(32'(shift_len), size));
  end

  shift_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (cnt_ld),
    .ld_val (len_q),
    .dec    (cnt_dec),
    .clr    (cnt_clr),
    .cnt    (cnt),
    .is_one (cnt_one)
  );

  always_comb begin
    state_nxt = state;
    ldR       = 1'b0;
    shrR      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ldR  = 1'b1;
        busy = 1'b1;
        if (abort) begin
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_ld    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        shrR = ~hold & ~abort;
        // Abort outranks hold: the transfer is dropped even while stalled.
        if (abort) begin
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (shrR) begin
          cnt_dec = 1'b1;
          if (cnt_one)
            state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign shifts_left = (state == S_SHIFT) ? cnt : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed scenarios then random traffic, all
// checked each cycle against a transaction-level model of the transfer.
module tb_shift_sequencer;

  localparam int SIZE  = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst, start, hold, abort;
  logic [CNT_W-1:0] shift_len;
  logic             ldR, shrR, busy, done;
  logic [CNT_W-1:0] shifts_left;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a transfer is either absent, waiting to load, or owes m_rem shifts.
  bit m_active   = 1'b0;
  bit m_loaded   = 1'b0;
  bit m_finish   = 1'b0;
  int m_rem      = 0;
  int m_len      = 0;
  int m_pulses   = 0;
  int m_xfers    = 0;

  shift_sequencer #(.size(SIZE), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .shift_len   (shift_len),
    .hold        (hold),
    .abort       (abort),
    .ldR         (ldR),
    .shrR        (shrR),
    .busy        (busy),
    .done        (done),
    .shifts_left (shifts_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit r, input bit s, input int len,
                      input bit h, input bit a);
    int e_ld, e_shr, e_busy, e_done, e_left;
    @(negedge clk);
    rst = r; start = s; shift_len = CNT_W'(len); hold = h; abort = a;
    #1;
    e_ld   = (m_active && !m_loaded) ? 1 : 0;
    e_shr  = (m_active && m_loaded && !h && !a) ? 1 : 0;
    e_busy = m_active ? 1 : 0;
    e_done = m_finish ? 1 : 0;
    e_left = (m_active && m_loaded) ? m_rem : 0;
    chk("ldR", int'(ldR), e_ld);
    chk("shrR", int'(shrR), e_shr);
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
    chk("shifts_left", int'(shifts_left), e_left);
    chk("ld_shr_excl", int'(ldR & shrR), 0);
    @(posedge clk);
    if (!r) begin
      m_active = 0; m_loaded = 0; m_finish = 0; m_rem = 0;
    end else if (m_finish) begin
      m_finish = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1; m_loaded = 0; m_pulses = 0;
        m_len = (len == 0 || len > SIZE) ? SIZE : len;
      end
    end else if (!m_loaded) begin
      if (a) m_active = 0;
      else begin m_loaded = 1; m_rem = m_len; end
    end else if (a) begin
      m_active = 0; m_rem = 0;
    end else if (!h) begin
      m_rem--;
      m_pulses++;
      if (m_rem == 0) begin
        m_active = 0; m_loaded = 0; m_finish = 1;
        m_xfers++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    int pulse_cnt, done_cyc;
    rst = 1'b0; start = 1'b0; shift_len = '0; hold = 1'b0; abort = 1'b0;

    // Reset and reset-state outputs
    step(0, 1, 5, 1, 1);
    step(0, 0, 0, 0, 0);
    idle(2);

    // Basic transfer of 5, counting pulses and done latency independently
    pulse_cnt = 0; done_cyc = -1;
    step(1, 1, 5, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      step(1, 0, 0, 0, 0);
      if (shrR) pulse_cnt++;
      if (done && done_cyc < 0) done_cyc = c;
    end
    chk("basic_pulses", pulse_cnt, 5);
    chk("basic_done_cycle", done_cyc, 7);

    // Clamping: zero and oversized lengths both give a full 16-shift transfer
    step(1, 1, 0, 0, 0);  idle(20);
    step(1, 1, 20, 0, 0); idle(20);
    step(1, 1, 16, 0, 0); idle(20);

    // Stall for two cycles mid-transfer
    step(1, 1, 4, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    idle(6);

    // Abort in SHIFT, abort while held, abort in LOAD; then a normal transfer
    step(1, 1, 8, 0, 0); idle(3); step(1, 0, 0, 0, 1); idle(2);
    step(1, 1, 8, 0, 0); idle(2); step(1, 0, 0, 1, 1); idle(2);
    step(1, 1, 8, 0, 0); step(1, 0, 0, 0, 1); idle(2);
    step(1, 1, 3, 0, 0); idle(6);

    // Reset mid-SHIFT, then start held through DONE of a prior transfer
    step(1, 1, 8, 0, 0); idle(3); step(0, 0, 0, 0, 0); idle(3);
    step(1, 1, 2, 0, 0); idle(2);
    for (int i = 0; i < 4; i++) step(1, 1, 9, 0, 0);
    idle(12);

    // Back-to-back with start held high
    for (int i = 0; i < 14; i++) step(1, 1, 2, 0, 0);
    idle(4);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 3),
           int'($urandom_range(0, 31)),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 39) == 0));
    end
    idle(20);
    chk("some_transfers_done", int'(m_xfers > 20), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "bench did not finish");
  end

endmodule
